// File: rtl/ucode_sequencer.sv
// Microcode sequencer: expands each accepted instruction into N+1 uops read from a
// zero-latency control store, with back-to-back acceptance on the last uop.
module ucode_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_opcode,
  input  logic        in_opcode_size,
  output logic        in_ready,
  output logic [7:0]  cs_opcode,
  output logic        cs_opcode_size,
  input  logic [63:0] cs_data,
  output logic        uop_valid,
  output logic [63:0] uop_ctrl,
  output logic [2:0]  uop_index,
  output logic        uop_last,
  input  logic        out_stall,
  input  logic        flush,
  output logic [15:0] stat_uops
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_op, w_op_nxt;
  logic        r_sz, w_sz_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [2:0]  r_n, w_n_nxt;
  logic        r_first, w_first_nxt;
  logic [15:0] r_stat, w_stat_nxt;

  logic [2:0]  w_n;
  logic        w_xfer;
  logic        w_accept;

  // The uop count is only valid from the control word on the first uop;
  // later uops use the copy captured on the first transfer.
  always_comb begin
    w_n       = r_first ? cs_data[63:61] : r_n;
    uop_valid = (r_state == RUN);
    uop_last  = uop_valid && (r_idx == w_n);
    uop_ctrl  = uop_valid ? {r_idx, cs_data[60:0]} : 64'h0;
    in_ready  = (r_state == IDLE) ? !flush : (uop_last && !out_stall && !flush);
    w_xfer    = uop_valid && !out_stall && !flush;
    w_accept  = in_valid && in_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_sz_nxt    = r_sz;
    w_idx_nxt   = r_idx;
    w_n_nxt     = r_n;
    w_first_nxt = r_first;
    w_stat_nxt  = r_stat;
    if (w_xfer)
      w_stat_nxt = r_stat + 16'd1;
    if (flush) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = 3'd0;
      w_first_nxt = 1'b0;
      w_n_nxt     = 3'd0;
    end else if (w_accept) begin
      // In RUN this coincides with the last uop's transfer: no bubble.
      w_state_nxt = RUN;
      w_op_nxt    = in_opcode;
      w_sz_nxt    = in_opcode_size;
      w_idx_nxt   = 3'd0;
      w_first_nxt = 1'b1;
    end else if (w_xfer) begin
      if (uop_last) begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
        w_first_nxt = 1'b0;
        w_n_nxt     = 3'd0;
      end else begin
        w_idx_nxt   = r_idx + 3'd1;
        w_n_nxt     = w_n;
        w_first_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= 8'h00;
      r_sz    <= 1'b0;
      r_idx   <= 3'd0;
      r_n     <= 3'd0;
      r_first <= 1'b0;
      r_stat  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_sz    <= w_sz_nxt;
      r_idx   <= w_idx_nxt;
      r_n     <= w_n_nxt;
      r_first <= w_first_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  assign cs_opcode      = r_op;
  assign cs_opcode_size = r_sz;
  assign uop_index      = r_idx;
  assign stat_uops      = r_stat;

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: the decode stage presents an instruction.
REQ-004 The block SHALL have the port in_opcode, input, 8 bits: the primary opcode.
REQ-005 The block SHALL have the port in_opcode_size, input, 1 bit: the operand-size select.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: the instruction is accepted when in_valid and in_ready are both high.
REQ-007 The block SHALL have the port cs_opcode, output, 8 bits: the registered control-store address.
REQ-008 The block SHALL have the port cs_opcode_size, output, 1 bit: the registered control-store size select.
REQ-009 The block SHALL have the port cs_data, input, 64 bits: the control word returned combinationally for cs_opcode/cs_opcode_size; bits [63:61] give the extra-uop count N (0-7), so the total is N+1 uops.
REQ-010 The block SHALL have the port uop_valid, output, 1 bit: a uop is presented downstream.
REQ-011 The block SHALL have the port uop_ctrl, output, 64 bits: the uop control word.
REQ-012 The block SHALL have the port uop_index, output, 3 bits: the index of the current uop within the instruction.
REQ-013 The block SHALL have the port uop_last, output, 1 bit: the current uop is the final uop of the instruction.
REQ-014 The block SHALL have the port out_stall, input, 1 bit: the downstream stage cannot accept.
REQ-015 The block SHALL have the port flush, input, 1 bit: a synchronous squash.
REQ-016 The block SHALL have the port stat_uops, output, 16 bits: the count of transferred uops.

Function
REQ-017 The block SHALL implement two states: IDLE and RUN.
REQ-018 In IDLE the block SHALL drive uop_valid=0 and in_ready=!flush.
REQ-019 On acceptance in IDLE, the block SHALL register in_opcode/in_opcode_size into cs_opcode/cs_opcode_size, set uop_index=0 and first=1, and go to RUN.
REQ-020 In RUN the block SHALL drive uop_valid=1.
REQ-021 The block SHALL define the effective count n as cs_data[63:61] when first=1, otherwise n_reg.
REQ-022 The block SHALL drive uop_last=(uop_index==n).
REQ-023 The block SHALL drive uop_ctrl = {uop_index, cs_data[60:0]} when uop_valid=1, and 64'h0 otherwise.
REQ-024 A uop transfer SHALL occur on a cycle with uop_valid=1 and out_stall=0.
REQ-025 On a transfer of a non-last uop, the block SHALL increment uop_index, load n_reg<=n, and clear first.
REQ-026 On a transfer of the last uop, the block SHALL go to IDLE, unless a new instruction is accepted in the same cycle.
REQ-027 In RUN the block SHALL drive in_ready = uop_last & !out_stall & !flush, giving back-to-back acceptance.
REQ-028 On acceptance in RUN, the block SHALL load the new opcode, set index=0 and first=1, and stay in RUN, so there are no bubble cycles.
REQ-029 While out_stall=1, the block SHALL hold all state, cs_opcode, uop_index, n_reg and first, and keep uop_ctrl stable.
REQ-030 flush SHALL take priority over everything: next state IDLE, uop_index=0, first=0, n_reg=0, no acceptance, stat_uops not incremented; cs_opcode SHALL be held.
REQ-031 The block SHALL increment stat_uops by 1 per transfer, wrapping modulo 2^16 (FFFF -> 0000).
REQ-032 uop_index SHALL never exceed n, so 8 uops maximum per instruction and no index wrap.
REQ-033 The control-store latency SHALL be zero cycles; the acceptance-to-first-uop latency SHALL be one cycle.

Reset
REQ-034 On reset=0, the block SHALL set state=IDLE, cs_opcode=8'h00, cs_opcode_size=0, uop_index=0, n_reg=0, first=0 and stat_uops=0, immediately and independent of clk.
REQ-035 While reset is asserted, the outputs SHALL be: uop_valid=0, uop_ctrl=0, uop_last=0, in_ready=1.
REQ-036 Asserting reset mid-sequence SHALL abandon the instruction; the first cycle after release is IDLE.

Verification
REQ-037 Single uop: accept 8'h90 with cs_data[63:61]=0 -> next cycle uop_valid=1, index 0, uop_last=1, in_ready=1; next cycle IDLE; stat_uops=1.
REQ-038 Three uops: field=2, out_stall=0 -> indices 0,1,2 on consecutive cycles; uop_last only on index 2; in_ready=0 during indices 0-1.
REQ-039 Stall: out_stall=1 for 3 cycles at index 1 -> index, uop_ctrl and stat_uops frozen; resume gives index 2 then IDLE.
REQ-040 Back-to-back: two single-uop instructions with in_valid held high -> two consecutive uop_valid cycles with different cs_opcode and no bubble.
REQ-041 Flush at index 1 of a 4-uop instruction -> next cycle uop_valid=0 and IDLE; stat_uops unchanged by the flushed cycle; a new instruction is accepted afterwards normally.
REQ-042 Wrap and reset: preload 16'hFFFF transfers -> one more gives stat_uops=0; asserting reset asynchronously mid-RUN -> uop_valid=0 before the next edge.
